axi_lite_reg_bridge: RTL and testbench

AXI_LITE_REG_BRIDGE -- requirements
Module: axi_lite_reg_bridge

---
 rtl/axi_pkg.sv | 64 ++++++
 rtl/axi_lite_reg_bridge.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: response codes and the request/response bus structs
// used by register-port bridges.
package axi_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned ID_W   = 10;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef logic [1:0] resp_code_t;

   localparam resp_code_t RESP_OKAY   = 2'b00;
   localparam resp_code_t RESP_EXOKAY = 2'b01;
   localparam resp_code_t RESP_SLVERR = 2'b10;
   localparam resp_code_t RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ax_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } w_chan_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      resp_code_t      resp;
   } b_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      resp_code_t        resp;
      logic              last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_resp_t;

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI4 slave to single-cycle register port bridge: one outstanding access,
// single-beat transfers only; bursts are drained and answered with SLVERR.
module axi_lite_reg_bridge #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter type         axi_req_t      = axi_pkg::axi_req_t,
   parameter type         axi_resp_t     = axi_pkg::axi_resp_t
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  axi_req_t                  axi_req_i,
   output axi_resp_t                 axi_resp_o,
   output logic [AXI_ADDR_WIDTH-1:0] address_o,
   output logic                      en_o,
   output logic                      we_o,
   input  logic [AXI_DATA_WIDTH-1:0] data_i,
   output logic [AXI_DATA_WIDTH-1:0] data_o
);

   localparam int unsigned DATA_W   = AXI_DATA_WIDTH;
   localparam int unsigned BUS_ID_W = axi_pkg::ID_W;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      WDRAIN,
      BRESP,
      RRESP
   } state_t;

   state_t                    r_state;
   logic                      r_rr_wr;
   logic                      r_is_wr;
   logic                      r_rd_err;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_W-1:0]         r_wdata;
   logic [DATA_W-1:0]         r_rdata;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [7:0]                r_len;
   logic [7:0]                r_cnt;
   axi_pkg::resp_code_t       r_bresp;
   logic                      r_en;
   logic                      r_we;
   logic                      r_bvalid;
   logic                      r_rvalid;

   logic w_wr_pend;
   logic w_rd_pend;
   logic w_grant_wr;
   logic w_grant_rd;
   logic w_r_last;
   logic w_unused;

   // A write needs AW and W together; the round-robin flag only matters on contention.
   assign w_wr_pend  = (r_state == IDLE) && axi_req_i.aw_valid && axi_req_i.w_valid;
   assign w_rd_pend  = (r_state == IDLE) && axi_req_i.ar_valid;
   assign w_grant_wr = w_wr_pend && (!w_rd_pend || r_rr_wr);
   assign w_grant_rd = w_rd_pend && !w_grant_wr;
   assign w_r_last   = !r_rd_err || (r_cnt == r_len);

   assign w_unused = ^{axi_req_i.aw.size, axi_req_i.aw.burst,
                       axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.w.strb};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_rr_wr  <= 1'b1;
         r_is_wr  <= 1'b0;
         r_rd_err <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_id     <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_bresp  <= axi_pkg::RESP_OKAY;
         r_en     <= 1'b0;
         r_we     <= 1'b0;
         r_bvalid <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_en <= 1'b0;
         r_we <= 1'b0;
         if (w_grant_wr || w_grant_rd) begin
            r_rr_wr <= ~r_rr_wr;
         end
         case (r_state)
            IDLE: begin
               if (w_grant_wr) begin
                  r_addr  <= AXI_ADDR_WIDTH'(axi_req_i.aw.addr);
                  r_id    <= AXI_ID_WIDTH'(axi_req_i.aw.id);
                  r_wdata <= DATA_W'(axi_req_i.w.data);
                  r_is_wr <= 1'b1;
                  if (axi_req_i.aw.len == 8'd0) begin
                     r_state <= ACCESS;
                     r_en    <= 1'b1;
                     r_we    <= 1'b1;
                  end else begin
                     r_state <= WDRAIN;
                     r_bresp <= axi_pkg::RESP_SLVERR;
                  end
               end else if (w_grant_rd) begin
                  r_addr  <= AXI_ADDR_WIDTH'(axi_req_i.ar.addr);
                  r_id    <= AXI_ID_WIDTH'(axi_req_i.ar.id);
                  r_len   <= axi_req_i.ar.len;
                  r_cnt   <= 8'd0;
                  r_is_wr <= 1'b0;
                  if (axi_req_i.ar.len == 8'd0) begin
                     r_state <= ACCESS;
                     r_en    <= 1'b1;
                  end else begin
                     // Unsupported read burst: answer every beat with zero data and SLVERR.
                     r_state  <= RRESP;
                     r_rd_err <= 1'b1;
                     r_rdata  <= '0;
                     r_rvalid <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (r_is_wr) begin
                  r_state  <= BRESP;
                  r_bresp  <= axi_pkg::RESP_OKAY;
                  r_bvalid <= 1'b1;
               end else begin
                  r_state  <= RRESP;
                  r_rdata  <= data_i;
                  r_rd_err <= 1'b0;
                  r_rvalid <= 1'b1;
               end
            end
            WDRAIN: begin
               if (axi_req_i.w_valid && axi_req_i.w.last) begin
                  r_state  <= BRESP;
                  r_bvalid <= 1'b1;
               end
            end
            BRESP: begin
               if (axi_req_i.b_ready) begin
                  r_state  <= IDLE;
                  r_bvalid <= 1'b0;
               end
            end
            RRESP: begin
               if (axi_req_i.r_ready) begin
                  if (w_r_last) begin
                     r_state  <= IDLE;
                     r_rvalid <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign address_o = r_addr;
   assign data_o    = r_wdata;
   assign en_o      = r_en;
   assign we_o      = r_we;

   // Ready strobes follow the grant directly so the handshake lands in the grant cycle.
   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.aw_ready = w_grant_wr;
      axi_resp_o.w_ready  = w_grant_wr || (r_state == WDRAIN);
      axi_resp_o.ar_ready = w_grant_rd;
      axi_resp_o.b_valid  = r_bvalid;
      axi_resp_o.b.id     = BUS_ID_W'(r_id);
      axi_resp_o.b.resp   = r_bresp;
      axi_resp_o.r_valid  = r_rvalid;
      axi_resp_o.r.id     = BUS_ID_W'(r_id);
      axi_resp_o.r.data   = r_rdata;
      axi_resp_o.r.resp   = r_rd_err ? axi_pkg::RESP_SLVERR : axi_pkg::RESP_OKAY;
      axi_resp_o.r.last   = w_r_last;
   end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge: expected register accesses and AXI
// responses are queued at issue time and checked by a monitor as they appear.
module tb_axi_lite_reg_bridge;

   logic                clk;
   logic                rst_n;
   axi_pkg::axi_req_t   req;
   axi_pkg::axi_resp_t  resp;
   logic [63:0]         address_o;
   logic                en_o;
   logic                we_o;
   logic [63:0]         data_i;
   logic [63:0]         data_o;
   logic [63:0]         rd_value;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   bit tb_rr = 1'b1;

   typedef struct { logic we; logic [63:0] addr; logic [63:0] data; int cyc; } en_exp_t;
   typedef struct { logic [9:0] id; logic [1:0] resp; int cyc; } b_exp_t;
   typedef struct { logic [9:0] id; logic [63:0] data; logic [1:0] resp; logic last; int cyc; } r_exp_t;

   en_exp_t exp_en[$];
   b_exp_t  exp_b[$];
   r_exp_t  exp_r[$];

   axi_lite_reg_bridge #(
      .AXI_ADDR_WIDTH (64),
      .AXI_DATA_WIDTH (64),
      .AXI_ID_WIDTH   (10),
      .axi_req_t      (axi_pkg::axi_req_t),
      .axi_resp_t     (axi_pkg::axi_resp_t)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .axi_req_i  (req),
      .axi_resp_o (resp),
      .address_o  (address_o),
      .en_o       (en_o),
      .we_o       (we_o),
      .data_i     (data_i),
      .data_o     (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file only presents the requested value while the strobe is high.
   assign data_i = en_o ? rd_value : 64'hDEAD_BEEF_DEAD_BEEF;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: every strobe and response handshake pops one expectation.
   always @(negedge clk) begin : mon
      en_exp_t e;
      b_exp_t  b;
      r_exp_t  r;
      if (rst_n) begin
         if (en_o) begin
            if (exp_en.size() == 0) chk("en_unexpected", 64'(en_o), 64'd0);
            else begin
               e = exp_en.pop_front();
               chk("en_we", 64'(we_o), 64'(e.we));
               chk("en_addr", address_o, e.addr);
               if (e.we) chk("en_data", data_o, e.data);
               if (e.cyc >= 0) chk("en_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (resp.b_valid && req.b_ready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'(resp.b_valid), 64'd0);
            else begin
               b = exp_b.pop_front();
               chk("b_id", 64'(resp.b.id), 64'(b.id));
               chk("b_resp", 64'(resp.b.resp), 64'(b.resp));
               if (b.cyc >= 0) chk("b_cycle", 64'(cyc), 64'(b.cyc));
            end
         end
         if (resp.r_valid && req.r_ready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 64'(resp.r_valid), 64'd0);
            else begin
               r = exp_r.pop_front();
               chk("r_id", 64'(resp.r.id), 64'(r.id));
               chk("r_data", resp.r.data, r.data);
               chk("r_resp", 64'(resp.r.resp), 64'(r.resp));
               chk("r_last", 64'(resp.r.last), 64'(r.last));
               if (r.cyc >= 0) chk("r_cycle", 64'(cyc), 64'(r.cyc));
            end
         end
      end
   end

   task automatic wait_drain();
      int k = 0;
      while ((exp_en.size() + exp_b.size() + exp_r.size()) != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("drain_pending", 64'(exp_en.size() + exp_b.size() + exp_r.size()), 64'd0);
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [9:0] id, input logic [63:0] data,
                           input logic [7:0] len, input int nbeats, input logic [7:0] strb,
                           input logic [1:0] burst, input bit chk_cyc);
      int k;
      int g;
      @(posedge clk); #1;
      req.aw       = '0;
      req.aw.addr  = addr;
      req.aw.id    = id;
      req.aw.len   = len;
      req.aw.burst = burst;
      req.aw_valid = 1'b1;
      req.w.data   = data;
      req.w.strb   = strb;
      req.w.last   = (nbeats == 1);
      req.w_valid  = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!resp.aw_ready && k < 20);
      chk("aw_ready", 64'(resp.aw_ready), 64'd1);
      chk("w_ready_first", 64'(resp.w_ready), 64'd1);
      g = cyc;
      tb_rr = ~tb_rr;
      if (len == 8'd0) exp_en.push_back('{1'b1, addr, data, chk_cyc ? g + 1 : -1});
      exp_b.push_back('{id, (len == 8'd0) ? axi_pkg::RESP_OKAY : axi_pkg::RESP_SLVERR,
                        chk_cyc ? g + 2 : -1});
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      for (int b = 1; b < nbeats; b++) begin
         req.w.data = data + 64'(b);
         req.w.last = (b == nbeats - 1);
         k = 0;
         do begin @(negedge clk); k++; end while (!resp.w_ready && k < 20);
         chk("w_ready_drain", 64'(resp.w_ready), 64'd1);
         @(posedge clk); #1;
      end
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [9:0] id, input logic [7:0] len,
                          input logic [63:0] value, input bit chk_cyc, output int g);
      int k;
      @(posedge clk); #1;
      rd_value     = value;
      req.ar       = '0;
      req.ar.addr  = addr;
      req.ar.id    = id;
      req.ar.len   = len;
      req.ar_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!resp.ar_ready && k < 20);
      chk("ar_ready", 64'(resp.ar_ready), 64'd1);
      g = cyc;
      tb_rr = ~tb_rr;
      if (len == 8'd0) begin
         exp_en.push_back('{1'b0, addr, 64'd0, chk_cyc ? g + 1 : -1});
         exp_r.push_back('{id, value, axi_pkg::RESP_OKAY, 1'b1, chk_cyc ? g + 2 : -1});
      end else begin
         for (int i = 0; i <= int'(len); i++)
            exp_r.push_back('{id, 64'd0, axi_pkg::RESP_SLVERR, (i == int'(len)), -1});
      end
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
   endtask

   // Write and read offered together; the model's round-robin flag picks the winner.
   task automatic contend(input logic [63:0] waddr, input logic [63:0] wdata, input logic [9:0] wid,
                          input logic [63:0] raddr, input logic [63:0] rdata, input logic [9:0] rid,
                          input bit exp_wr);
      int g;
      @(posedge clk); #1;
      rd_value     = rdata;
      req.aw       = '0;
      req.aw.addr  = waddr;
      req.aw.id    = wid;
      req.aw_valid = 1'b1;
      req.w.data   = wdata;
      req.w.strb   = 8'hFF;
      req.w.last   = 1'b1;
      req.w_valid  = 1'b1;
      req.ar       = '0;
      req.ar.addr  = raddr;
      req.ar.id    = rid;
      req.ar_valid = 1'b1;
      @(negedge clk);
      chk("rr_model", 64'(tb_rr), 64'(exp_wr));
      chk("rr_aw_ready", 64'(resp.aw_ready), 64'(tb_rr));
      chk("rr_ar_ready", 64'(resp.ar_ready), 64'(!tb_rr));
      g = cyc;
      if (tb_rr) begin
         exp_en.push_back('{1'b1, waddr, wdata, g + 1});
         exp_b.push_back('{wid, axi_pkg::RESP_OKAY, g + 2});
      end else begin
         exp_en.push_back('{1'b0, raddr, 64'd0, g + 1});
         exp_r.push_back('{rid, rdata, axi_pkg::RESP_OKAY, 1'b1, g + 2});
      end
      tb_rr = ~tb_rr;
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      req.w_valid  = 1'b0;
      req.ar_valid = 1'b0;
      wait_drain();
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      tb_rr = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int g;
      int k;
      rst_n    = 1'b0;
      req      = '0;
      rd_value = '0;
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_en", 64'(en_o), 64'd0);
      chk("rst_we", 64'(we_o), 64'd0);
      chk("rst_addr", address_o, 64'd0);
      chk("rst_data", data_o, 64'd0);
      chk("rst_bvalid", 64'(resp.b_valid), 64'd0);
      chk("rst_rvalid", 64'(resp.r_valid), 64'd0);
      req.aw_valid = 1'b1;
      #1;
      chk("aw_alone_ready", 64'(resp.aw_ready), 64'd0);
      req.aw_valid = 1'b0;
      rst_n = 1'b1;

      // AW without W is never accepted
      @(posedge clk); #1;
      req.aw.addr  = 64'h100;
      req.aw_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("aw_alone_ready_idle", 64'(resp.aw_ready), 64'd0);
      end
      @(posedge clk); #1;
      req.aw_valid = 1'b0;

      // Single write with fixed latency
      do_write(64'h4000, 10'd3, 64'h55, 8'd0, 1, 8'hFF, 2'b01, 1'b1);
      wait_drain();

      // Strobe and burst type are ignored; full data is presented
      do_write(64'h10, 10'd1, 64'hFFEE_DDCC_BBAA_9988, 8'd0, 1, 8'h01, 2'b10, 1'b1);
      wait_drain();

      // Single read with r_ready held low for 5 cycles
      req.r_ready = 1'b0;
      do_read(64'hBFF8, 10'd7, 8'd0, 64'h1234, 1'b0, g);
      repeat (5) begin
         @(negedge clk);
         if (cyc >= g + 2) begin
            chk("rhold_valid", 64'(resp.r_valid), 64'd1);
            chk("rhold_data", resp.r.data, 64'h1234);
         end
      end
      chk("rhold_first_cycle", 64'(cyc), 64'(g + 5));
      repeat (5) begin
         @(negedge clk);
         chk("rhold_valid", 64'(resp.r_valid), 64'd1);
         chk("rhold_data", resp.r.data, 64'h1234);
      end
      @(posedge clk); #1;
      req.r_ready = 1'b1;
      wait_drain();

      // Normal read with fixed latency, all-ones data
      do_read(64'h0, 10'h3FF, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, g);
      wait_drain();

      // Read burst len=3: four SLVERR beats, no strobe
      do_read(64'h200, 10'd9, 8'd3, 64'h0, 1'b0, g);
      wait_drain();

      // Write burst len=2 with three beats: one SLVERR response, no strobe
      do_write(64'h300, 10'd4, 64'hA0, 8'd2, 3, 8'hFF, 2'b01, 1'b0);
      wait_drain();

      // Contention from reset: write, read, write
      pulse_reset();
      contend(64'h1000, 64'h11, 10'd1, 64'h2000, 64'h22, 10'd2, 1'b1);
      contend(64'h1008, 64'h33, 10'd3, 64'h2008, 64'h44, 10'd4, 1'b0);
      contend(64'h1010, 64'h55, 10'd5, 64'h2010, 64'h66, 10'd6, 1'b1);

      // Reset while a write response is stalled in BRESP
      req.b_ready = 1'b0;
      do_write(64'h8, 10'd5, 64'h77, 8'd0, 1, 8'hFF, 2'b01, 1'b0);
      k = 0;
      while (!resp.b_valid && k < 20) begin @(negedge clk); k++; end
      chk("bresp_reached", 64'(resp.b_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_bvalid_async", 64'(resp.b_valid), 64'd0);
      chk("rst_en_async", 64'(en_o), 64'd0);
      exp_b.delete();
      tb_rr = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req.b_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_bvalid", 64'(resp.b_valid), 64'd0);
      do_read(64'h40, 10'd8, 8'd0, 64'hCAFE_F00D_0000_0001, 1'b1, g);
      wait_drain();

      repeat (3) @(negedge clk);
      chk("idle_rvalid", 64'(resp.r_valid), 64'd0);
      chk("idle_bvalid", 64'(resp.b_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
